dm_port_ctrl: RTL
=================

Name: dm_port_ctrl

Overview:
- Data-memory port controller between the MEM stage and the word-wide data memory.
- Turns MEM's single-cycle read/write request into a valid/ack memory transaction and holds the pipeline with FREEZE until the transaction completes.
- Implements SB/SH as read-modify-write. Word order is big-endian: byte 0 = [31:24].
- Returns the raw read word to MEM's data_read_fDM input.

Parameters:
- OP_SB, 6'b101000, ALU_control code for store byte
- OP_SH, 6'b101001, ALU_control code for store halfword
- ACK_TIMEOUT, 16, cycles to wait for mem_ack before abort (>=1)

Ports:
- CLK  in  1  clock
- RESET  in  1  reset
- req_read  in  1  MemRead_2DM from MEM
- req_write  in  1  MemWrite_2DM from MEM
- req_op  in  6  ALU_control of the MEM instruction
- req_addr  in  32  data_address_2DM
- req_wdata  in  32  data_write_2DM
- FREEZE  out  1  pipeline stall, combinational
- rdata  out  32  read word to MEM (data_read_fDM)
- bus_err  out  1  one-cycle timeout pulse
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word address ({req_addr[31:2],2'b00})
- mem_wdata  out  32  write word
- mem_ack  in  1  memory completion; read data valid this cycle
- mem_rdata  in  32  memory read word

Behaviour:
- Reset is RESET, asynchronous, active-high; clock is CLK.
- Reset values: state IDLE; mem_req, mem_we, bus_err = 0; rdata, mem_addr, mem_wdata, timeout count = 0.
- State machine states: IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
- FREEZE = (state==IDLE && (req_read||req_write)) || (state!=IDLE && state!=DONE).
  - In DONE, FREEZE is 0 and the pipeline advances at the following edge.
- IDLE:
  - Latch addr, wdata and op on the edge where a request is present.
  - Priority: req_write over req_read.
  - Write with op==OP_SB or OP_SH goes to RMW_RD. Any other write goes to WR. A read goes to RD.
- RD:
  - mem_req=1, mem_we=0.
  - On mem_ack: rdata<=mem_rdata, then DONE.
- WR:
  - mem_req=1, mem_we=1, mem_wdata=latched wdata.
  - On mem_ack: DONE.
- RMW_RD:
  - Same as RD, but on ack merge store data into mem_rdata and go to RMW_WR. rdata is not updated.
  - SB lane, by addr[1:0]: 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0]. Source is wdata[7:0].
  - SH lane, by addr[1]: 0 -> [31:16], 1 -> [15:0]. Source is wdata[15:0].
- RMW_WR: mem_req=1, mem_we=1, merged word. On mem_ack: DONE.
- DONE: mem_req=0; next state IDLE unconditionally.
  - A new request is therefore seen in IDLE the cycle after DONE.
- mem_req, mem_we, mem_addr and mem_wdata are registered and stay stable from assertion until the ack cycle. mem_req drops the cycle after ack.
- Minimum latency, ack in the first mem_req cycle:
  - read/SW: 3 cycles of request visibility, 2 of them frozen.
  - SB/SH: 4 cycles, 3 frozen.
- Timeout:
  - The counter clears on entry to any access state and increments each cycle mem_req=1 without ack.
  - On reaching ACK_TIMEOUT: bus_err=1 for one cycle, go to DONE, drop mem_req.
  - On a read timeout, rdata<=32'hDEADBEEF. A store timeout writes nothing further.
- mem_ack while mem_req=0 is ignored.
- Reset mid-transaction: immediately IDLE, mem_req=0, FREEZE follows the IDLE equation. The transaction is abandoned.
- Inputs are sampled only in IDLE; changes during other states are ignored.

Optional Feature:
- Macro: DM_MISALIGN_TRAP_EN.
- Defined: adds output misalign_exc (1 bit, reset 0).
  - In IDLE, a misaligned request goes straight to DONE with no memory access, and misalign_exc=1 in that DONE cycle.
  - Misaligned means: SH with addr[0]=1, or a non-SB/SH write or read with addr[1:0]!=0.
- Not defined: no port. Low address bits are ignored except for SB/SH lane selection, with SH using addr[1] only.

Test Plan:
- Read, addr 0x100, mem_ack in first cycle, mem_rdata 0x11223344 -> mem_addr 0x100, FREEZE 1 for 2 cycles, rdata 0x11223344 in DONE, one mem_req cycle.
- SW addr 0x204 wdata 0xCAFEBABE, ack delayed 3 cycles -> mem_we=1, mem_wdata stable 4 cycles, FREEZE 1 for 5 cycles then 0.
- SB addr 0x303 wdata 0x000000AB, memory word 0x11223344 -> RMW read, then write of 0x112233AB to 0x300; SH addr 0x302 wdata 0x5566 -> write 0x11225566.
- No ack for ACK_TIMEOUT=16 cycles on read -> bus_err pulse, rdata 0xDEADBEEF, mem_req deasserts, FREEZE releases in DONE.
- Back-to-back read then write, plus req_read=req_write=1 -> the second request starts the cycle after DONE; the simultaneous request is treated as a write.
- RESET asserted in RMW_WR -> mem_req 0 asynchronously, state IDLE. With DM_MISALIGN_TRAP_EN, SW to 0x101 -> no mem_req, misalign_exc pulse.

Source files
------------

// File: rtl/dm_port_ctrl_if.sv
// Bundle between the MEM stage, the data-memory port controller and the data memory.
// With DM_MISALIGN_TRAP_EN defined the bundle also carries misalign_exc.
interface dm_port_ctrl_if;
  logic        req_read;
  logic        req_write;
  logic [5:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        FREEZE;
  logic [31:0] rdata;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef DM_MISALIGN_TRAP_EN
  logic        misalign_exc;
`endif

  // Handshake: mem_req/mem_we/mem_addr/mem_wdata are held stable from the
  // cycle mem_req rises until the cycle mem_ack=1 is seen with mem_req=1;
  // that cycle completes the transfer (and carries read data), and mem_req
  // falls on the following cycle. mem_ack with mem_req=0 carries no meaning.
  modport master (
    input  req_read, req_write, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
    output FREEZE, rdata, bus_err, mem_req, mem_we, mem_addr, mem_wdata
`ifdef DM_MISALIGN_TRAP_EN
    , output misalign_exc
`endif
  );

  modport slave (
    output req_read, req_write, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
    input  FREEZE, rdata, bus_err, mem_req, mem_we, mem_addr, mem_wdata
`ifdef DM_MISALIGN_TRAP_EN
    , input misalign_exc
`endif
  );
endinterface

// File: rtl/dm_port_ctrl.sv
// Data-memory port controller: turns MEM-stage requests into valid/ack memory
// transfers, stalls the pipeline via FREEZE, does SB/SH as read-modify-write.
// Optional misaligned-access trap: define DM_MISALIGN_TRAP_EN.
module dm_port_ctrl #(
  parameter logic [5:0] OP_SB       = 6'b101000,
  parameter logic [5:0] OP_SH       = 6'b101001,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic           CLK,
  input  logic           RESET,
  dm_port_ctrl_if.master bus,
  output logic [2:0]     dbg_state_o
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD     = 3'd1;
  localparam logic [2:0] WR     = 3'd2;
  localparam logic [2:0] RMW_RD = 3'd3;
  localparam logic [2:0] RMW_WR = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          bus_err_q, bus_err_d;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [1:0]    lane_q, lane_d;
  logic          is_sh_q, is_sh_d;
  logic          misalign_q, misalign_d;

  logic req_any;
  logic is_sb_op;
  logic is_sh_op;
  logic misaligned;
  logic access_state;
  logic timed_out;

  // Big-endian lanes: byte 0 is [31:24]; SH picks its half by lane[1] only.
  function automatic logic [31:0] merge_word(input logic [31:0] word,
                                             input logic [15:0] src,
                                             input logic [1:0]  lane,
                                             input logic        sh);
    logic [31:0] m;
    m = word;
    if (sh) begin
      if (lane[1]) m[15:0]  = src;
      else         m[31:16] = src;
    end else begin
      case (lane)
        2'd0:    m[31:24] = src[7:0];
        2'd1:    m[23:16] = src[7:0];
        2'd2:    m[15:8]  = src[7:0];
        default: m[7:0]   = src[7:0];
      endcase
    end
    return m;
  endfunction

  assign req_any      = bus.req_read | bus.req_write;
  assign is_sb_op     = (bus.req_op == OP_SB);
  assign is_sh_op     = (bus.req_op == OP_SH);
  assign access_state = (state_q == RD) || (state_q == WR) ||
                        (state_q == RMW_RD) || (state_q == RMW_WR);
  assign timed_out    = (tmo_cnt_q == CW'(ACK_TIMEOUT - 1));

`ifdef DM_MISALIGN_TRAP_EN
  assign misaligned = bus.req_write ?
                        (is_sh_op ? bus.req_addr[0] :
                         is_sb_op ? 1'b0 : (|bus.req_addr[1:0])) :
                        (|bus.req_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    bus_err_d   = 1'b0;
    tmo_cnt_d   = tmo_cnt_q;
    lane_d      = lane_q;
    is_sh_d     = is_sh_q;
    misalign_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_any) begin
          mem_addr_d  = {bus.req_addr[31:2], 2'b00};
          mem_wdata_d = bus.req_wdata;
          lane_d      = bus.req_addr[1:0];
          is_sh_d     = is_sh_op;
          tmo_cnt_d   = '0;
          if (misaligned) begin
            state_d    = DONE;
            misalign_d = 1'b1;
          end else if (bus.req_write) begin
            mem_req_d = 1'b1;
            if (is_sb_op || is_sh_op) begin
              state_d  = RMW_RD;
              mem_we_d = 1'b0;
            end else begin
              state_d  = WR;
              mem_we_d = 1'b1;
            end
          end else begin
            state_d   = RD;
            mem_req_d = 1'b1;
            mem_we_d  = 1'b0;
          end
        end
      end

      RD, WR, RMW_RD, RMW_WR: begin
        if (bus.mem_ack) begin
          if (state_q == RMW_RD) begin
            // The merged word is issued as a fresh write with its own timeout window.
            state_d     = RMW_WR;
            mem_we_d    = 1'b1;
            mem_wdata_d = merge_word(bus.mem_rdata, mem_wdata_q[15:0], lane_q, is_sh_q);
            tmo_cnt_d   = '0;
          end else begin
            if (state_q == RD) rdata_d = bus.mem_rdata;
            state_d   = DONE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
          end
        end else if (timed_out) begin
          if (state_q == RD) rdata_d = 32'hDEADBEEF;
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
      tmo_cnt_q   <= '0;
      lane_q      <= '0;
      is_sh_q     <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      bus_err_q   <= bus_err_d;
      tmo_cnt_q   <= tmo_cnt_d;
      lane_q      <= lane_d;
      is_sh_q     <= is_sh_d;
      misalign_q  <= misalign_d;
    end
  end

  // DONE is the one cycle the pipeline advances; IDLE stalls only on a live request.
  assign bus.FREEZE    = ((state_q == IDLE) && req_any) || access_state;
  assign bus.rdata     = rdata_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign dbg_state_o   = state_q;

`ifdef DM_MISALIGN_TRAP_EN
  assign bus.misalign_exc = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q ^ misaligned;
`endif

endmodule
